// File: rtl/cand_sender_pkg.sv
// Shared definitions for the candidate sender and the downstream min-tracker:
// default word widths and the sender state encoding.
package cand_sender_pkg;

    localparam int unsigned COST_W_DEF = 18;
    localparam int unsigned POS_W_DEF  = 6;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StReq,
        StSetup,
        StPulse,
        StFin
    } cand_state_e;

endpackage

// File: rtl/cand_sender.sv
// Walks disparities 0..max_disp, fetches each cost from the cost source and presents
// it to the min-tracker with a setup cycle before every update pulse.
module cand_sender
    import cand_sender_pkg::*;
#(
    parameter int unsigned COST_W = COST_W_DEF,
    parameter int unsigned POS_W  = POS_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [POS_W-1:0]  max_disp,
    output logic              cost_req,
    output logic [POS_W-1:0]  cost_addr,
    input  logic              cost_valid,
    input  logic [COST_W-1:0] cost_data,
    output logic              startsig,
    output logic              update,
    output logic [COST_W-1:0] in,
    output logic [POS_W-1:0]  inp,
    output logic              busy,
    output logic              done
);

    cand_state_e       r_state;
    logic [POS_W-1:0]  r_d;
    logic [POS_W-1:0]  r_maxd;
    logic              r_cost_req;
    logic [POS_W-1:0]  r_cost_addr;
    logic              r_startsig;
    logic              r_update;
    logic [COST_W-1:0] r_in;
    logic [POS_W-1:0]  r_inp;
    logic              r_busy;
    logic              r_done;

    // Each output is set on the edge entering the state that owns it, so it is
    // high for exactly that state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_d         <= '0;
            r_maxd      <= '0;
            r_cost_req  <= 1'b0;
            r_cost_addr <= '0;
            r_startsig  <= 1'b0;
            r_update    <= 1'b0;
            r_in        <= '0;
            r_inp       <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_startsig <= 1'b0;
            r_update   <= 1'b0;
            r_done     <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (go) begin
                        r_state    <= StStart;
                        r_maxd     <= max_disp;
                        r_d        <= '0;
                        r_busy     <= 1'b1;
                        r_startsig <= 1'b1;
                    end
                end
                StStart: begin
                    r_state     <= StReq;
                    r_cost_req  <= 1'b1;
                    r_cost_addr <= r_d;
                end
                StReq: begin
                    if (cost_valid) begin
                        r_state    <= StSetup;
                        r_cost_req <= 1'b0;
                        r_in       <= cost_data;
                        r_inp      <= r_d;
                    end
                end
                StSetup: begin
                    r_state  <= StPulse;
                    r_update <= 1'b1;
                end
                StPulse: begin
                    // Compare before incrementing so a full-range sweep never wraps d.
                    if (r_d == r_maxd) begin
                        r_state <= StFin;
                        r_done  <= 1'b1;
                    end else begin
                        r_state     <= StReq;
                        r_d         <= r_d + 1'b1;
                        r_cost_req  <= 1'b1;
                        r_cost_addr <= r_d + 1'b1;
                    end
                end
                StFin: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign cost_req  = r_cost_req;
    assign cost_addr = r_cost_addr;
    assign startsig  = r_startsig;
    assign update    = r_update;
    assign in        = r_in;
    assign inp       = r_inp;
    assign busy      = r_busy;
    assign done      = r_done;

endmodule

// File: tb/tb_cand_sender.sv
// Scenario bench for cand_sender: a delay-programmable cost source, a min-tracker model
// and a scoreboard of (cost, disparity) pairs checked on every update pulse.
module tb_cand_sender;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        go = 1'b0;
    logic [5:0]  max_disp = '0;
    logic        cost_req;
    logic [5:0]  cost_addr;
    logic        cost_valid;
    logic [17:0] cost_data;
    logic        startsig, update, busy, done;
    logic [17:0] in;
    logic [5:0]  inp;

    cand_sender dut (
        .clk(clk), .rst(rst), .go(go), .max_disp(max_disp),
        .cost_req(cost_req), .cost_addr(cost_addr),
        .cost_valid(cost_valid), .cost_data(cost_data),
        .startsig(startsig), .update(update), .in(in), .inp(inp),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc++;

    // Cost source: answers cost_req after dly[addr] cycles of waiting.
    logic [17:0] costs[64];
    int          dly[64];
    logic        src_valid = 1'b0;
    logic        inj_valid = 1'b0;
    logic [17:0] src_data = '0;
    int          wait_cnt = 0;
    logic [23:0] exp_q[$];

    assign cost_valid = src_valid | inj_valid;
    assign cost_data  = inj_valid ? 18'd999 : src_data;

    always @(negedge clk) begin
        if (rst) begin
            src_valid = 1'b0;
            wait_cnt  = 0;
        end else if (cost_req && !src_valid) begin
            if (wait_cnt >= dly[cost_addr]) begin
                src_valid = 1'b1;
                src_data  = costs[cost_addr];
                exp_q.push_back({costs[cost_addr], cost_addr});
            end else begin
                wait_cnt++;
            end
        end else begin
            src_valid = 1'b0;
            wait_cnt  = 0;
        end
    end

    // Monitor: scoreboard, stability checks and min-tracker model.
    int          start_cnt = 0, upd_cnt = 0, done_cnt = 0, req1_cnt = 0;
    int          done_cyc = 0, last_upd_cyc = 0, go_cyc = 0;
    logic [5:0]  last_inp = '0, first_inp = '0;
    logic [17:0] prev_in = '0, trk_min = '0;
    logic [5:0]  prev_inp = '0, trk_pos = '0;
    logic [23:0] exp_e;

    always @(negedge clk) begin
        if (!rst) begin
            if (startsig && update) begin
                n_tests++; n_fail++;
                $display("FAIL start_update_overlap: both high at cycle %0d", cyc);
            end
            if (startsig) begin
                start_cnt++;
                trk_min = '1;
                trk_pos = '0;
            end
            if (cost_req) begin
                n_tests++;
                if (in !== prev_in || inp !== prev_inp) begin
                    n_fail++;
                    $display("FAIL hold_in_req: in/inp %0d/%0d, required %0d/%0d",
                             in, inp, prev_in, prev_inp);
                end
                if (cost_addr == 6'd1) req1_cnt++;
            end
            if (update) begin
                upd_cnt++;
                if (upd_cnt == 1) first_inp = inp;
                last_inp     = inp;
                last_upd_cyc = cyc;
                n_tests++;
                if (in !== prev_in || inp !== prev_inp) begin
                    n_fail++;
                    $display("FAIL setup_stable: in/inp %0d/%0d, required %0d/%0d",
                             in, inp, prev_in, prev_inp);
                end
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: update with in=%0d inp=%0d, none expected",
                             in, inp);
                end else begin
                    exp_e = exp_q.pop_front();
                    if ({in, inp} !== exp_e) begin
                        n_fail++;
                        $display("FAIL update_value: in/inp %0d/%0d, required %0d/%0d",
                                 in, inp, exp_e[23:6], exp_e[5:0]);
                    end
                end
                if (in < trk_min) begin
                    trk_min = in;
                    trk_pos = inp;
                end
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
        prev_in  = in;
        prev_inp = inp;
    end

    task automatic pulse_go(input logic [5:0] m);
        @(negedge clk);
        max_disp = m;
        go       = 1'b1;
        go_cyc   = cyc;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic wait_done(input int limit, input string name);
        int base;
        base = done_cnt;
        for (int i = 0; i < limit && done_cnt == base; i++) @(negedge clk);
        n_tests++;
        if (done_cnt == base) begin
            n_fail++;
            $display("FAIL %s_timeout: no done within %0d cycles, required one", name, limit);
        end
    endtask

    task automatic check_int(input string name, input int act, input int req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic set_source(input int delay, input int cost);
        for (int i = 0; i < 64; i++) begin
            dly[i]   = delay;
            costs[i] = 18'(cost);
        end
    endtask

    task automatic test_reset;
        #1;
        n_tests++;
        if ({cost_req, cost_addr, startsig, update, in, inp, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b addr=%0d st=%b up=%b in=%0d inp=%0d busy=%b done=%b, required all 0",
                     cost_req, cost_addr, startsig, update, in, inp, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_sweep;
        int s0;
        set_source(1, 0);
        costs[0] = 18'd40; costs[1] = 18'd12; costs[2] = 18'd12; costs[3] = 18'd30;
        s0 = start_cnt;
        upd_cnt = 0;
        pulse_go(6'd3);
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_busy: got %b, required 1", busy);
        end
        wait_done(100, "basic");
        check_int("basic_startsig_cnt", start_cnt - s0, 1);
        check_int("basic_update_cnt", upd_cnt, 4);
        check_int("basic_last_inp", int'(last_inp), 3);
        check_int("basic_tracker_out", int'(trk_min), 12);
        check_int("basic_tracker_outp", int'(trk_pos), 1);
        check_int("basic_done_after_update", done_cyc - last_upd_cyc, 1);
        @(negedge clk);
        check_int("basic_busy_cleared", int'(busy), 0);
    endtask

    task automatic test_single;
        set_source(1, 7);
        upd_cnt = 0;
        pulse_go(6'd0);
        wait_done(50, "single");
        check_int("single_update_cnt", upd_cnt, 1);
        check_int("single_latency", done_cyc - go_cyc, 6);
        check_int("single_first_inp", int'(first_inp), 0);
    endtask

    task automatic test_stall;
        set_source(1, 3);
        dly[1] = 5;
        upd_cnt  = 0;
        req1_cnt = 0;
        pulse_go(6'd2);
        wait_done(100, "stall");
        check_int("stall_req_cycles_d1", req1_cnt, 6);
        check_int("stall_update_cnt", upd_cnt, 3);
    endtask

    task automatic test_ignored_inputs;
        int s0, d0, k;
        set_source(1, 0);
        for (int i = 0; i < 4; i++) costs[i] = 18'(i + 1);
        s0 = start_cnt;
        d0 = done_cnt;
        upd_cnt = 0;
        pulse_go(6'd3);
        k = 0;
        while (upd_cnt == 0 && k < 50) begin @(negedge clk); k++; end
        while (!cost_req && k < 50) begin @(negedge clk); k++; end
        while (cost_req && k < 50) begin @(negedge clk); k++; end
        check_int("ignore_reached_setup", int'(k < 50), 1);
        // Now in the setup cycle of d=1.
        inj_valid = 1'b1;
        go        = 1'b1;
        max_disp  = 6'd0;
        @(negedge clk);
        inj_valid = 1'b0;
        go        = 1'b0;
        wait_done(100, "ignore");
        check_int("ignore_update_cnt", upd_cnt, 4);
        check_int("ignore_startsig_cnt", start_cnt - s0, 1);
        check_int("ignore_done_cnt", done_cnt - d0, 1);
        check_int("ignore_scoreboard_left", exp_q.size(), 0);
    endtask

    task automatic test_reset_mid_sweep;
        int s0, d0, k;
        set_source(1, 9);
        upd_cnt = 0;
        pulse_go(6'd5);
        k = 0;
        while (!(update && inp == 6'd2) && k < 100) begin @(negedge clk); k++; end
        check_int("rstmid_reached_pulse2", int'(k < 100), 1);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({cost_req, cost_addr, startsig, update, in, inp, busy, done} !== '0) begin
            n_fail++;
            $display("FAIL rstmid_outputs: req=%b addr=%0d up=%b in=%0d inp=%0d busy=%b done=%b, required all 0",
                     cost_req, cost_addr, update, in, inp, busy, done);
        end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        repeat (3) @(negedge clk);
        check_int("rstmid_no_done", done_cnt - d0, 0);
        s0 = start_cnt;
        upd_cnt = 0;
        pulse_go(6'd1);
        wait_done(100, "rstmid");
        check_int("rstmid_restart_startsig", start_cnt - s0, 1);
        check_int("rstmid_restart_first_inp", int'(first_inp), 0);
        check_int("rstmid_restart_update_cnt", upd_cnt, 2);
    endtask

    task automatic test_full_range;
        set_source(0, 5);
        upd_cnt = 0;
        pulse_go(6'd63);
        wait_done(400, "full");
        check_int("full_update_cnt", upd_cnt, 64);
        check_int("full_last_inp", int'(last_inp), 63);
        check_int("full_tracker_outp", int'(trk_pos), 0);
        check_int("full_scoreboard_left", exp_q.size(), 0);
    endtask

    initial begin
        set_source(1, 0);
        test_reset();
        test_basic_sweep();
        test_single();
        test_stall();
        test_ignored_inputs();
        test_reset_mid_sweep();
        test_full_range();
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/cand_sender.md
CAND_SENDER -- requirements
Module: cand_sender

Interface
REQ-001 Parameter COST_W, default 18, width of a matching-cost word.
REQ-002 Parameter POS_W, default 6, width of a disparity index.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 go  input  1  one-cycle request to start a disparity sweep.
REQ-006 max_disp  input  POS_W  last disparity index of the sweep; sampled when go is accepted.
REQ-007 cost_req  output  1  cost-source request, held high until cost_valid.
REQ-008 cost_addr  output  POS_W  disparity whose cost is requested.
REQ-009 cost_valid  input  1  cost-source response strobe.
REQ-010 cost_data  input  COST_W  cost for cost_addr, valid with cost_valid.
REQ-011 startsig  output  1  one-cycle pulse that arms the downstream min-tracker.
REQ-012 update  output  1  one-cycle pulse; downstream samples in/inp on its rising edge.
REQ-013 in  output  COST_W  candidate cost to the tracker.
REQ-014 inp  output  POS_W  candidate disparity to the tracker.
REQ-015 busy  output  1  high from go acceptance until done.
REQ-016 done  output  1  one-cycle pulse after the last update.

Function
REQ-017 States: IDLE, START, REQ, SETUP, PULSE, FIN; all outputs registered.
REQ-018 IDLE: go=1 -> START; max_disp latched; disparity counter d cleared to 0; busy set.
REQ-019 START: startsig=1 for exactly this cycle -> REQ.
REQ-020 REQ: cost_req=1, cost_addr=d; stays in REQ until cost_valid=1, then in<=cost_data, inp<=d -> SETUP.
REQ-021 SETUP: update=0, in/inp stable (setup cycle for the downstream edge) -> PULSE.
REQ-022 PULSE: update=1 for one cycle, in/inp unchanged; if d==latched max_disp -> FIN, else d<=d+1 -> REQ.
REQ-023 FIN: done=1 for one cycle, busy cleared -> IDLE.
REQ-024 in/inp hold their last value from PULSE until the next capture in REQ; they never change while update=1 or in the cycle before update rises.
REQ-025 startsig and update are never high in the same cycle; at least one cycle separates startsig from the first update.
REQ-026 Sweep emits exactly max_disp+1 updates, indices 0..max_disp ascending; max_disp=0 gives one update.
REQ-027 max_disp = 2^POS_W-1 is legal; d never wraps, the sweep ends at PULSE with d==max_disp.
REQ-028 go while busy is ignored; cost_valid outside REQ is ignored.
REQ-029 Minimum cycles per candidate: 3 (REQ with immediate cost_valid, SETUP, PULSE); an arbitrary cost_valid delay stretches REQ only.
REQ-030 Minimum sweep latency go -> done = 3*(max_disp+1)+3 cycles.

Reset
REQ-031 rst=1 forces IDLE asynchronously, independent of clk.
REQ-032 Reset values: startsig, update, cost_req, busy, done = 0; in, inp, cost_addr, d, latched max_disp = 0.
REQ-033 Reset mid-sweep abandons the sweep with no done pulse; the first go after reset release starts a fresh sweep from d=0.

Structure
REQ-034 Shared package holds COST_W, POS_W defaults and the state enumeration, shared with the min-tracker side.
REQ-035 Single module; no sub-module.

Verification
REQ-036 max_disp=3, cost_valid one cycle after each cost_req, costs 40,12,12,30 -> one startsig, then 4 updates with inp 0,1,2,3 and in 40,12,12,30; tracker reports out=12, outp=1; done after the last update.
REQ-037 max_disp=0, cost 7 -> exactly one update (in=7, inp=0); done 6 cycles after go.
REQ-038 cost_valid delayed 5 cycles for d=1 -> cost_req/cost_addr=1 held 6 cycles; no update during the wait; in/inp unchanged until capture.
REQ-039 go pulsed again mid-sweep and cost_valid pulsed in SETUP -> ignored; update count and values unchanged.
REQ-040 rst asserted during the PULSE of d=2 -> all outputs 0 immediately; no done; the next go yields a startsig and d restarting at 0.
REQ-041 max_disp=63, constant costs -> 64 updates, last inp=63, no counter wrap, tracker outp=0.
